// File: rtl/mmio_intr_ctrl.sv
// IOBUS-mapped interrupt controller: synchronises up to 16 event sources, latches
// rising edges as pending/overflow bits, counts accepted edges and drives INTR.

module mmio_intr_src (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_src,
  input  logic i_pend_clr,
  input  logic i_ovf_clr,
  output logic o_edge,
  output logic o_pend,
  output logic o_ovf
);
  logic r_sync1, r_sync2, r_sync3, r_pend, r_ovf;
  logic w_edge;

  assign w_edge = r_sync2 & ~r_sync3;

  // A new edge beats a same-cycle W1C; overflow only counts against a bit that survives the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pend  <= (r_pend & ~i_pend_clr) | w_edge;
      r_ovf   <= (r_ovf & ~i_ovf_clr) | (w_edge & r_pend & ~i_pend_clr);
    end
  end

  assign o_edge = w_edge;
  assign o_pend = r_pend;
  assign o_ovf  = r_ovf;
endmodule

module mmio_intr_ctrl #(
  parameter int          N_SRC   = 4,
  parameter logic [31:0] BASE_AD = 32'h11000060
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] SRC,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      RD_DATA,
  output logic             INTR
);
  localparam logic [31:0] PEND_AD  = BASE_AD;
  localparam logic [31:0] MASK_AD  = BASE_AD + 32'd4;
  localparam logic [31:0] COUNT_AD = BASE_AD + 32'd8;

  logic [N_SRC-1:0] r_mask;
  logic [15:0]      r_count;
  logic             r_intr;

  logic [N_SRC-1:0] w_edge, w_pend, w_ovf, w_pend_clr, w_ovf_clr;
  logic             w_sel_pend, w_sel_mask, w_sel_count;
  logic             w_wr_pend, w_wr_mask, w_wr_count;
  logic [4:0]       w_edge_cnt;
  logic [16:0]      w_count_sum;
  logic [15:0]      w_count_sat;
  logic             w_unused;

  assign w_sel_pend  = (IOBUS_ADDR == PEND_AD);
  assign w_sel_mask  = (IOBUS_ADDR == MASK_AD);
  assign w_sel_count = (IOBUS_ADDR == COUNT_AD);
  assign w_wr_pend   = IOBUS_WR & w_sel_pend;
  assign w_wr_mask   = IOBUS_WR & w_sel_mask;
  assign w_wr_count  = IOBUS_WR & w_sel_count;

  assign w_pend_clr = w_wr_pend ? IOBUS_OUT[N_SRC-1:0]    : '0;
  assign w_ovf_clr  = w_wr_pend ? IOBUS_OUT[16 +: N_SRC] : '0;
  assign w_unused   = ^IOBUS_OUT;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    mmio_intr_src u_src (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_src      (SRC[g]),
      .i_pend_clr (w_pend_clr[g]),
      .i_ovf_clr  (w_ovf_clr[g]),
      .o_edge     (w_edge[g]),
      .o_pend     (w_pend[g]),
      .o_ovf      (w_ovf[g])
    );
  end

  always_comb begin
    w_edge_cnt = '0;
    for (int i = 0; i < N_SRC; i++) w_edge_cnt = w_edge_cnt + 5'(w_edge[i]);
  end

  assign w_count_sum = {1'b0, r_count} + 17'(w_edge_cnt);
  assign w_count_sat = w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];

  // A COUNT write restarts from zero but still keeps this cycle's edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask  <= '0;
      r_count <= '0;
      r_intr  <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= IOBUS_OUT[N_SRC-1:0];
      r_count <= w_wr_count ? 16'(w_edge_cnt) : w_count_sat;
      r_intr  <= |(w_pend & r_mask);
    end
  end

  always_comb begin
    RD_DATA = '0;
    if (w_sel_pend) begin
      RD_DATA[N_SRC-1:0]    = w_pend;
      RD_DATA[16 +: N_SRC] = w_ovf;
    end else if (w_sel_mask) begin
      RD_DATA[N_SRC-1:0] = r_mask;
    end else if (w_sel_count) begin
      RD_DATA[15:0] = r_count;
    end
  end

  assign INTR = r_intr;
endmodule

// File: tb/tb_mmio_intr_ctrl.sv
// Directed self-checking bench for mmio_intr_ctrl (N_SRC=4, default base address).

module tb_mmio_intr_ctrl;
  localparam logic [31:0] PEND_AD  = 32'h11000060;
  localparam logic [31:0] MASK_AD  = 32'h11000064;
  localparam logic [31:0] COUNT_AD = 32'h11000068;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  SRC = '0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  mmio_intr_ctrl #(.N_SRC(4), .BASE_AD(32'h11000060)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SRC        (SRC),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_OUT  = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    #1;
    d = RD_DATA;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick();
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp %h", d, 32'h0); end
    rd(MASK_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", d, 32'h0); end
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", d, 32'h0); end
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", INTR); end
  endtask

  task automatic test_poll_masked();
    logic [31:0] d;
    SRC[0] = 1'b1;
    tick(5);
    SRC[0] = 1'b0;
    tick(3);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL poll_pend got %h exp %h", d, 32'h1); end
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL poll_count got %h exp %h", d, 32'h1); end
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL poll_intr got %b exp 0", INTR); end
  endtask

  task automatic test_intr_latency();
    logic [31:0] d;
    wr(PEND_AD, 32'h1);
    wr(MASK_AD, 32'h1);
    SRC[0] = 1'b1;
    tick(3);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL lat_pend_e2 got %h exp %h", d, 32'h1); end
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL lat_intr_e2 got %b exp 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL lat_intr_e3 got %b exp 1", INTR); end
    SRC[0] = 1'b0;
    tick();
    IOBUS_ADDR = PEND_AD;
    IOBUS_OUT  = 32'h1;
    IOBUS_WR   = 1'b1;
    #1;
    checks++; if (RD_DATA !== 32'h1) begin errors++; $display("FAIL rd_during_wr got %h exp %h", RD_DATA, 32'h1); end
    tick();
    IOBUS_WR  = 1'b0;
    IOBUS_OUT = '0;
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend got %h exp %h", d, 32'h0); end
    tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL w1c_intr got %b exp 0", INTR); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr(MASK_AD, 32'h0);
    wr(COUNT_AD, 32'h0);
    SRC[2] = 1'b1; tick(2);
    SRC[2] = 1'b0; tick(2);
    SRC[2] = 1'b1; tick(2);
    SRC[2] = 1'b0; tick(4);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h00040004) begin errors++; $display("FAIL ovf_pend got %h exp %h", d, 32'h00040004); end
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovf_count got %h exp %h", d, 32'h2); end
    wr(PEND_AD, 32'h00040004);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_clear got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    wr(COUNT_AD, 32'h0);
    SRC = 4'hF; tick(2);
    SRC = 4'h0; tick(4);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL simul_count got %h exp %h", d, 32'h4); end
    rd(PEND_AD, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL simul_pend got %h exp %h", d, 32'hF); end
    wr(MASK_AD, 32'hFFFFFFFF);
    rd(MASK_AD, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL mask_rd got %h exp %h", d, 32'hF); end
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_on_e0 got %b exp 0", INTR); end
    tick();
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL mask_on_e1 got %b exp 1", INTR); end
    wr(MASK_AD, 32'h0);
    checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL mask_off_e0 got %b exp 1", INTR); end
    tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mask_off_e1 got %b exp 0", INTR); end
    wr(PEND_AD, 32'h000F000F);
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    wr(COUNT_AD, 32'h0);
    for (int i = 0; i < 16383; i++) begin
      SRC = 4'hF; tick();
      SRC = 4'h0; tick();
    end
    tick(4);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'hFFFC) begin errors++; $display("FAIL sat_pre got %h exp %h", d, 32'hFFFC); end
    SRC = 4'hF; tick();
    SRC = 4'h0; tick(4);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp %h", d, 32'hFFFF); end
    for (int i = 0; i < 3; i++) begin
      SRC = 4'hF; tick();
      SRC = 4'h0; tick();
    end
    tick(4);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp %h", d, 32'hFFFF); end
    rd(PEND_AD, d);
    checks++; if (d !== 32'h000F000F) begin errors++; $display("FAIL sat_pend got %h exp %h", d, 32'h000F000F); end
    wr(COUNT_AD, 32'h0);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL count_clr got %h exp %h", d, 32'h0); end
    wr(PEND_AD, 32'h000F000F);
  endtask

  task automatic test_collision();
    logic [31:0] d;
    SRC[1] = 1'b1; tick(2);
    SRC[1] = 1'b0; tick(4);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL coll_setup got %h exp %h", d, 32'h2); end
    SRC[1] = 1'b1;
    tick(2);
    wr(PEND_AD, 32'h2);
    SRC[1] = 1'b0;
    tick(3);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL coll_pend got %h exp %h", d, 32'h2); end
    SRC[3] = 1'b1;
    tick(2);
    wr(COUNT_AD, 32'h0);
    SRC[3] = 1'b0;
    tick(3);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL coll_count got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_reset_held();
    logic [31:0] d;
    SRC[0] = 1'b1;
    RST = 1'b1;
    tick();
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_pend got %h exp %h", d, 32'h0); end
    tick(2);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_held_pend got %h exp %h", d, 32'h0); end
    RST = 1'b0;
    tick(2);
    rd(PEND_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_rel_e2 got %h exp %h", d, 32'h0); end
    tick();
    rd(PEND_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_rel_e3 got %h exp %h", d, 32'h1); end
    SRC[0] = 1'b0;
    tick(3);
    rd(COUNT_AD, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_rel_count got %h exp %h", d, 32'h1); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    rd(32'h11000000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_other got %h exp %h", d, 32'h0); end
    rd(32'h1100006C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_plus12 got %h exp %h", d, 32'h0); end
    wr(32'h21000064, 32'hFFFFFFFF);
    wr(32'h11000070, 32'hFFFFFFFF);
    rd(MASK_AD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_mask got %h exp %h", d, 32'h0); end
    tick();
    checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL dec_intr got %b exp 0", INTR); end
  endtask

  initial begin
    tick();
    test_reset();
    test_poll_masked();
    test_intr_latency();
    test_overflow();
    test_simultaneous();
    test_saturation();
    test_collision();
    test_reset_held();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_intr_ctrl.md
Name: mmio_intr_ctrl

Overview:
- Memory-mapped interrupt controller that sits on the OTTER IOBUS beside the switch/LED/SSEG decode in the board wrapper.
- Takes up to 16 asynchronous board event sources (buttons, peripheral done strobes) and synchronises them.
- Latches rising edges as pending bits and drives the single INTR input of OTTER_MCU.
- The CPU reads cause/status over IOBUS and acknowledges by write-1-to-clear, closing the loop from the MCU side.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16).
- BASE_AD, 32'h11000060, byte address of the first register; registers at BASE_AD+0, +4, +8.

Ports:
- CLK  input  1  system clock (clk_50 domain of the MCU).
- RST  input  1  synchronous, active-high reset.
- SRC  input  N_SRC  raw asynchronous event inputs, active high.
- IOBUS_ADDR  input  32  CPU bus address.
- IOBUS_OUT  input  32  CPU write data.
- IOBUS_WR  input  1  CPU write strobe, one cycle per store.
- RD_DATA  output  32  read data, combinational on IOBUS_ADDR; ORed into the wrapper's IOBUS_IN mux.
- INTR  output  1  registered interrupt request to OTTER_MCU.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high: RST sampled high at a CLK rising edge clears all state.
- Register map:
  - PEND (BASE_AD+0): read {OVF[N_SRC-1:0] at bits 31:16, PEND[N_SRC-1:0] at bits 15:0}, unused bits 0. Write: each 1 in bits 15:0 clears PEND, each 1 in bits 31:16 clears OVF; 0 bits have no effect.
  - MASK (BASE_AD+4): read/write, bits N_SRC-1:0; upper bits read 0.
  - COUNT (BASE_AD+8): read-only 16-bit count of accepted edges, zero-extended; saturates at 16'hFFFF. Any write clears it.
- Address decode is an exact 32-bit match. Writes to other addresses are ignored; reads of other addresses return 32'h0.
- Synchroniser, per source: sync1 <= SRC, sync2 <= sync1, sync3 <= sync2. edge = sync2 & ~sync3.
- Latency: if SRC rises before CLK edge e0, sync2 is high after e1, the PEND bit is set after e2, and INTR is high after e3. That is 3 clocks from input to INTR.
- Pending: an edge sets PEND[i] regardless of MASK, so sources can be polled. If PEND[i] is already 1 when a new edge arrives, OVF[i] is set and COUNT still increments.
- COUNT: increments by the number of edges in the cycle (popcount, N_SRC simultaneous edges allowed), saturating.
- Edge and W1C clear of the same PEND bit in the same cycle: set wins, and OVF is not set. The same set-wins rule applies to OVF, and to COUNT increment versus COUNT clear.
- INTR <= |(PEND & MASK), registered. It deasserts one clock after the clearing write, or after the MASK write that masks the last pending bit.
- A MASK write takes effect on INTR at the next edge.
- Reset values:
  - sync1/2/3, PEND, OVF, MASK, COUNT all 0; INTR 0.
  - Because sync3 resets to 0, a source held high through reset produces one edge three cycles after RST falls. This is intended: the level is reported.
- Reset mid-operation clears all pending state; no edge is lost or doubled for sources low during reset.
- RD_DATA reflects register contents as of the current cycle. A read in the same cycle as a write returns the pre-write value.
- No read side effects.

Test Plan:
- Reset, then MASK=4'h0 and pulse SRC[0] high for 5 clocks -> PEND reads 32'h00000001, COUNT=1, INTR stays 0.
- MASK=4'h1, pulse SRC[0] -> INTR high exactly 3 clocks after SRC rises. Write PEND 32'h00000001 -> INTR low next clock and PEND reads 0.
- Pulse SRC[2] twice without clearing -> PEND=32'h00040004, COUNT=2. Writing 32'h00040004 clears both bits.
- Assert SRC[3:0]=4'hF in one cycle -> COUNT increments by 4 and PEND low nibble is F. Preload COUNT to saturation by 65535+ edges -> stays 16'hFFFF.
- Schedule the SRC[1] edge to reach PEND in the same cycle as a W1C write of bit 1 -> PEND[1]=1 after, OVF[1]=0.
- Hold SRC[0] high across RST -> no PEND during reset, PEND[0]=1 three cycles after RST falls. Read of 32'h11000000 -> RD_DATA=0.
